sys_ctrl_cmd: RTL

//  Command sequencer behind the UART receiver. It consumes received bytes (RX_P_DATA/RX_D_VLD) and decodes
//  the framed commands: register write, register read, ALU op with operands, and ALU op without operands.
//  It drives the register file and the ALU, and returns results to the UART transmitter byte by byte.
//  It is the only master of the register file and the ALU in the system.

---
 rtl/sys_ctrl_cmd_if.sv | 34 +++
 rtl/sys_ctrl_cmd.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_cmd_if.sv
// rtl/sys_ctrl_cmd_if.sv - UART/register-file/ALU signal bundle for the command sequencer
interface sys_ctrl_cmd_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_OUT_WIDTH = 16
);
   logic [DATA_WIDTH-1:0]    RX_P_DATA;
   logic                     RX_D_VLD;
   logic [DATA_WIDTH-1:0]    RdData;
   logic                     RdData_Valid;
   logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
   logic                     OUT_Valid;
   logic                     TX_BUSY;
   logic                     WrEn;
   logic                     RdEn;
   logic [ADDR_WIDTH-1:0]    Address;
   logic [DATA_WIDTH-1:0]    WrData;
   logic                     ALU_EN;
   logic [3:0]               ALU_FUN;
   logic                     CLK_GATE_EN;
   logic [DATA_WIDTH-1:0]    TX_P_DATA;
   logic                     TX_D_VLD;
   logic                     frame_drop;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_BUSY,
      output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, frame_drop
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_BUSY,
      input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, frame_drop
   );
endinterface

// File: rtl/sys_ctrl_cmd.sv
// rtl/sys_ctrl_cmd.sv - command sequencer: decodes UART frames, drives register file and ALU, returns results
module sys_ctrl_cmd #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_OUT_WIDTH = 16
) (
   input  logic          CLK,
   input  logic          RST,
   sys_ctrl_cmd_if.master bus
);
   localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_OP  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_NOP = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
      S_OP_A, S_OP_B, S_OP_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI
   } state_t;

   typedef enum logic [1:0] {TX_SEND, TX_WAIT_HI, TX_WAIT_LO} tx_phase_t;

   state_t                   state_q, state_d;
   tx_phase_t                tx_phase_q, tx_phase_d;
   logic                     two_byte_q, two_byte_d;
   logic [ALU_OUT_WIDTH-1:0] result_q, result_d;
   logic                     wr_en_q, wr_en_d;
   logic                     rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0]    address_q, address_d;
   logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
   logic                     alu_en_q, alu_en_d;
   logic [3:0]               alu_fun_q, alu_fun_d;
   logic                     clk_gate_en_q, clk_gate_en_d;
   logic [DATA_WIDTH-1:0]    tx_p_data_q, tx_p_data_d;
   logic                     tx_d_vld_q, tx_d_vld_d;
   logic                     frame_drop_q, frame_drop_d;

   always_comb begin
      state_d       = state_q;
      tx_phase_d    = tx_phase_q;
      two_byte_d    = two_byte_q;
      result_d      = result_q;
      address_d     = address_q;
      wr_data_d     = wr_data_q;
      alu_fun_d     = alu_fun_q;
      tx_p_data_d   = tx_p_data_q;
      wr_en_d       = 1'b0;
      rd_en_d       = 1'b0;
      alu_en_d      = 1'b0;
      tx_d_vld_d    = 1'b0;
      frame_drop_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.RX_D_VLD) begin
               case (bus.RX_P_DATA)
                  CMD_WR:  state_d = S_WR_ADDR;
                  CMD_RD:  state_d = S_RD_ADDR;
                  CMD_OP:  state_d = S_OP_A;
                  CMD_NOP: state_d = S_OP_FUN;
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_WR_ADDR: if (bus.RX_D_VLD) begin
            address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
            state_d   = S_WR_DATA;
         end
         S_WR_DATA: if (bus.RX_D_VLD) begin
            wr_data_d = bus.RX_P_DATA;
            wr_en_d   = 1'b1;
            state_d   = S_IDLE;
         end
         S_RD_ADDR: if (bus.RX_D_VLD) begin
            address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_d   = 1'b1;
            state_d   = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            frame_drop_d = bus.RX_D_VLD;
            if (bus.RdData_Valid) begin
               result_d   = {{(ALU_OUT_WIDTH-DATA_WIDTH){1'b0}}, bus.RdData};
               two_byte_d = 1'b0;
               tx_phase_d = TX_SEND;
               state_d    = S_TX_LO;
            end
         end
         // Operands land in registers 0 and 1, where the ALU reads them.
         S_OP_A: if (bus.RX_D_VLD) begin
            address_d = '0;
            wr_data_d = bus.RX_P_DATA;
            wr_en_d   = 1'b1;
            state_d   = S_OP_B;
         end
         S_OP_B: if (bus.RX_D_VLD) begin
            address_d = ADDR_WIDTH'(1);
            wr_data_d = bus.RX_P_DATA;
            wr_en_d   = 1'b1;
            state_d   = S_OP_FUN;
         end
         S_OP_FUN: if (bus.RX_D_VLD) begin
            alu_fun_d = bus.RX_P_DATA[3:0];
            alu_en_d  = 1'b1;
            state_d   = S_ALU_WAIT;
         end
         S_ALU_WAIT: begin
            frame_drop_d = bus.RX_D_VLD;
            if (bus.OUT_Valid) begin
               result_d   = bus.ALU_OUT;
               two_byte_d = 1'b1;
               tx_phase_d = TX_SEND;
               state_d    = S_TX_LO;
            end
         end
         S_TX_LO, S_TX_HI: begin
            frame_drop_d = bus.RX_D_VLD;
            // Each byte: request once the link is idle, then see a full busy high/low cycle.
            case (tx_phase_q)
               TX_SEND: if (!bus.TX_BUSY) begin
                  tx_p_data_d = (state_q == S_TX_HI) ? result_q[ALU_OUT_WIDTH-1:DATA_WIDTH]
                                                     : result_q[DATA_WIDTH-1:0];
                  tx_d_vld_d  = 1'b1;
                  tx_phase_d  = TX_WAIT_HI;
               end
               TX_WAIT_HI: if (bus.TX_BUSY) tx_phase_d = TX_WAIT_LO;
               TX_WAIT_LO: if (!bus.TX_BUSY) begin
                  tx_phase_d = TX_SEND;
                  state_d    = (state_q == S_TX_LO && two_byte_q) ? S_TX_HI : S_IDLE;
               end
               default: tx_phase_d = TX_SEND;
            endcase
         end
         default: state_d = S_IDLE;
      endcase

      clk_gate_en_d = (state_d == S_OP_FUN) || (state_d == S_ALU_WAIT);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q       <= S_IDLE;
         tx_phase_q    <= TX_SEND;
         two_byte_q    <= 1'b0;
         result_q      <= '0;
         wr_en_q       <= 1'b0;
         rd_en_q       <= 1'b0;
         address_q     <= '0;
         wr_data_q     <= '0;
         alu_en_q      <= 1'b0;
         alu_fun_q     <= '0;
         clk_gate_en_q <= 1'b0;
         tx_p_data_q   <= '0;
         tx_d_vld_q    <= 1'b0;
         frame_drop_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         tx_phase_q    <= tx_phase_d;
         two_byte_q    <= two_byte_d;
         result_q      <= result_d;
         wr_en_q       <= wr_en_d;
         rd_en_q       <= rd_en_d;
         address_q     <= address_d;
         wr_data_q     <= wr_data_d;
         alu_en_q      <= alu_en_d;
         alu_fun_q     <= alu_fun_d;
         clk_gate_en_q <= clk_gate_en_d;
         tx_p_data_q   <= tx_p_data_d;
         tx_d_vld_q    <= tx_d_vld_d;
         frame_drop_q  <= frame_drop_d;
      end
   end

   assign bus.WrEn        = wr_en_q;
   assign bus.RdEn        = rd_en_q;
   assign bus.Address     = address_q;
   assign bus.WrData      = wr_data_q;
   assign bus.ALU_EN      = alu_en_q;
   assign bus.ALU_FUN     = alu_fun_q;
   assign bus.CLK_GATE_EN = clk_gate_en_q;
   assign bus.TX_P_DATA   = tx_p_data_q;
   assign bus.TX_D_VLD    = tx_d_vld_q;
   assign bus.frame_drop  = frame_drop_q;
endmodule
